recover_2n_feeder: RTL and testbench

//  Frame sequencer that drives the input side of the 2N-point recovery stage.

---
 rtl/recover_2n_feeder.sv | 156 +++++++++++++++
 tb/tb_recover_2n_feeder.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/recover_2n_feeder.sv
// Frame sequencer for the 2N-point recovery stage: walks beat addresses through the
// X1/X2 result banks and presents each returned word as unpacked lanes with column indices.

module recover_2n_feeder_lane #(
  parameter int DATA_WIDTH = 27
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cap,
  input  logic [3:0][DATA_WIDTH-1:0] x1_slot,
  input  logic [3:0][DATA_WIDTH-1:0] x2_slot,
  output logic [DATA_WIDTH-1:0]      x1_c1r,
  output logic [DATA_WIDTH-1:0]      x1_c1i,
  output logic [DATA_WIDTH-1:0]      x1_c2r,
  output logic [DATA_WIDTH-1:0]      x1_c2i,
  output logic [DATA_WIDTH-1:0]      x2_c1r,
  output logic [DATA_WIDTH-1:0]      x2_c1i,
  output logic [DATA_WIDTH-1:0]      x2_c2r,
  output logic [DATA_WIDTH-1:0]      x2_c2i
);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x1_c1r <= '0; x1_c1i <= '0; x1_c2r <= '0; x1_c2i <= '0;
      x2_c1r <= '0; x2_c1i <= '0; x2_c2r <= '0; x2_c2i <= '0;
    end else if (cap) begin
      x1_c1r <= x1_slot[0]; x1_c1i <= x1_slot[1]; x1_c2r <= x1_slot[2]; x1_c2i <= x1_slot[3];
      x2_c1r <= x2_slot[0]; x2_c1i <= x2_slot[1]; x2_c2r <= x2_slot[2]; x2_c2i <= x2_slot[3];
    end
  end
endmodule

module recover_2n_feeder #(
  parameter int DATA_WIDTH  = 27,
  parameter int NUM_BEATS   = 1024,
  parameter int INDEX_WIDTH = 11,
  parameter int RD_LAT      = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         hold,
  output logic                         busy,
  output logic                         done,
  output logic                         rd_en,
  output logic [$clog2(NUM_BEATS)-1:0] rd_addr,
  input  logic [16*DATA_WIDTH-1:0]     rd_data_x1,
  input  logic [16*DATA_WIDTH-1:0]     rd_data_x2,
  output logic                         valid,
  output logic [3:0][DATA_WIDTH-1:0]   x1_col1_r,
  output logic [3:0][DATA_WIDTH-1:0]   x1_col1_i,
  output logic [3:0][DATA_WIDTH-1:0]   x1_col2_r,
  output logic [3:0][DATA_WIDTH-1:0]   x1_col2_i,
  output logic [3:0][DATA_WIDTH-1:0]   x2_col1_r,
  output logic [3:0][DATA_WIDTH-1:0]   x2_col1_i,
  output logic [3:0][DATA_WIDTH-1:0]   x2_col2_r,
  output logic [3:0][DATA_WIDTH-1:0]   x2_col2_i,
  output logic [INDEX_WIDTH-1:0]       index_col_1,
  output logic [INDEX_WIDTH-1:0]       index_col_2
);
  localparam int AW = $clog2(NUM_BEATS);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                 state, state_nx;
  logic [AW-1:0]          beat, beat_nx, issue_addr;
  logic                   issue, done_nx;
  logic [RD_LAT:0]        vld_pipe;
  logic [RD_LAT:0][AW-1:0] idx_pipe;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // A start taken in IDLE issues beat 0 in the same cycle unless hold is up.
  always_comb begin
    state_nx   = state;
    beat_nx    = beat;
    issue      = 1'b0;
    issue_addr = beat;
    done_nx    = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_nx   = ISSUE;
        issue_addr = '0;
        beat_nx    = '0;
        if (!hold) begin
          issue   = 1'b1;
          beat_nx = AW'(1);
        end
      end
      ISSUE: if (!hold) begin
        issue   = 1'b1;
        beat_nx = beat + AW'(1);
        if (beat == AW'(NUM_BEATS - 1)) state_nx = DRAIN;
      end
      DRAIN: if (vld_pipe == '0) begin
        state_nx = IDLE;
        done_nx  = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  // vld_pipe[0]/idx_pipe[0] are the read strobe/address; stage RD_LAT lines up with bank data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      vld_pipe    <= '0;
      idx_pipe    <= '0;
      valid       <= 1'b0;
      index_col_1 <= '0;
      index_col_2 <= '0;
    end else begin
      beat     <= beat_nx;
      busy     <= (state_nx != IDLE);
      done     <= done_nx;
      vld_pipe <= {vld_pipe[RD_LAT-1:0], issue};
      if (issue) idx_pipe[0] <= issue_addr;
      for (int k = 1; k <= RD_LAT; k++) idx_pipe[k] <= idx_pipe[k-1];
      valid <= vld_pipe[RD_LAT];
      if (vld_pipe[RD_LAT]) begin
        index_col_1 <= INDEX_WIDTH'(idx_pipe[RD_LAT]);
        index_col_2 <= INDEX_WIDTH'(idx_pipe[RD_LAT]) + INDEX_WIDTH'(NUM_BEATS);
      end
    end
  end

  assign rd_en   = vld_pipe[0];
  assign rd_addr = idx_pipe[0];

  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [3:0][DATA_WIDTH-1:0] x1_slot, x2_slot;
    for (genvar s = 0; s < 4; s++) begin : g_slot
      assign x1_slot[s] = rd_data_x1[(4*s+l)*DATA_WIDTH +: DATA_WIDTH];
      assign x2_slot[s] = rd_data_x2[(4*s+l)*DATA_WIDTH +: DATA_WIDTH];
    end
    recover_2n_feeder_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .cap    (vld_pipe[RD_LAT]),
      .x1_slot(x1_slot),
      .x2_slot(x2_slot),
      .x1_c1r (x1_col1_r[l]),
      .x1_c1i (x1_col1_i[l]),
      .x1_c2r (x1_col2_r[l]),
      .x1_c2i (x1_col2_i[l]),
      .x2_c1r (x2_col1_r[l]),
      .x2_c1i (x2_col1_i[l]),
      .x2_c2r (x2_col2_r[l]),
      .x2_c2i (x2_col2_i[l])
    );
  end
endmodule

// File: tb/tb_recover_2n_feeder.sv
// Directed bench: cycle-pattern checks on rd_en/valid/done/busy plus a beat scoreboard
// comparing indices and all 32 lane fields against an address-tagged bank model.
module tb_recover_2n_feeder;
  localparam int DW = 27;
  localparam int NB = 4;
  localparam int IW = 11;
  localparam int RL = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              hold = 1'b0;
  logic              busy, done, rd_en, valid;
  logic [1:0]        rd_addr;
  logic [16*DW-1:0]  rd_data_x1, rd_data_x2, rnd_x1, rnd_x2;
  logic [3:0][DW-1:0] x1_col1_r, x1_col1_i, x1_col2_r, x1_col2_i;
  logic [3:0][DW-1:0] x2_col1_r, x2_col1_i, x2_col2_r, x2_col2_i;
  logic [IW-1:0]     index_col_1, index_col_2;
  logic              rnd_mode = 1'b1;
  logic [1:0]        a_d1 = '0, a_d2 = '0;

  int checks = 0;
  int failures = 0;
  int exp_q[$];

  recover_2n_feeder #(.DATA_WIDTH(DW), .NUM_BEATS(NB), .INDEX_WIDTH(IW), .RD_LAT(RL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hold(hold), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data_x1(rd_data_x1), .rd_data_x2(rd_data_x2),
    .valid(valid),
    .x1_col1_r(x1_col1_r), .x1_col1_i(x1_col1_i), .x1_col2_r(x1_col2_r), .x1_col2_i(x1_col2_i),
    .x2_col1_r(x2_col1_r), .x2_col1_i(x2_col1_i), .x2_col2_r(x2_col2_r), .x2_col2_i(x2_col2_i),
    .index_col_1(index_col_1), .index_col_2(index_col_2)
  );

  always #5 clk = ~clk;

  // Bank field tag: address 0 gives the plain 16'hA000/16'hB000 + 4*s + l pattern.
  function automatic logic [DW-1:0] fld(input bit b, input int a, input int s, input int l);
    return DW'((b ? 32'hB000 : 32'hA000) + (a << 8) + 4*s + l);
  endfunction

  // Two-cycle read latency bank model, independent of rd_en.
  always @(posedge clk) begin
    a_d1 <= rd_addr;
    a_d2 <= a_d1;
  end

  always_comb begin
    rd_data_x1 = rnd_x1;
    rd_data_x2 = rnd_x2;
    if (!rnd_mode)
      for (int s = 0; s < 4; s++)
        for (int l = 0; l < 4; l++) begin
          rd_data_x1[(4*s+l)*DW +: DW] = fld(1'b0, int'(a_d2), s, l);
          rd_data_x2[(4*s+l)*DW +: DW] = fld(1'b1, int'(a_d2), s, l);
        end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every presented beat must match the next expected index.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat: got index %0d expected no beat", index_col_1);
      end else begin
        int e;
        e = exp_q.pop_front();
        chk("index_col_1", 128'(index_col_1), 128'(e));
        chk("index_col_2", 128'(index_col_2), 128'(e + NB));
        for (int l = 0; l < 4; l++) begin
          chk($sformatf("x1_col1_r[%0d]", l), 128'(x1_col1_r[l]), 128'(fld(1'b0, e, 0, l)));
          chk($sformatf("x1_col1_i[%0d]", l), 128'(x1_col1_i[l]), 128'(fld(1'b0, e, 1, l)));
          chk($sformatf("x1_col2_r[%0d]", l), 128'(x1_col2_r[l]), 128'(fld(1'b0, e, 2, l)));
          chk($sformatf("x1_col2_i[%0d]", l), 128'(x1_col2_i[l]), 128'(fld(1'b0, e, 3, l)));
          chk($sformatf("x2_col1_r[%0d]", l), 128'(x2_col1_r[l]), 128'(fld(1'b1, e, 0, l)));
          chk($sformatf("x2_col1_i[%0d]", l), 128'(x2_col1_i[l]), 128'(fld(1'b1, e, 1, l)));
          chk($sformatf("x2_col2_r[%0d]", l), 128'(x2_col2_r[l]), 128'(fld(1'b1, e, 2, l)));
          chk($sformatf("x2_col2_i[%0d]", l), 128'(x2_col2_i[l]), 128'(fld(1'b1, e, 3, l)));
        end
      end
    end
  end

  task automatic push_frame(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(i);
  endtask

  // Cycle k: sample outputs at its negedge, then drive the inputs it presents to the next edge.
  task automatic run_seq(input logic [31:0] st, input logic [31:0] hd, input logic [31:0] rs,
                         input int n, output logic [31:0] re, output logic [31:0] va,
                         output logic [31:0] dn, output logic [31:0] bz);
    re = '0; va = '0; dn = '0; bz = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      re[k] = rd_en; va[k] = valid; dn[k] = done; bz[k] = busy;
      start = st[k]; hold = hd[k]; rst_n = ~rs[k];
    end
    start = 1'b0; hold = 1'b0; rst_n = 1'b1;
  endtask

  task automatic chk_seq(input string t, input logic [31:0] re, va, dn, bz,
                         input logic [31:0] ere, eva, edn, ebz);
    chk({t, "_rd_en"}, 128'(re), 128'(ere));
    chk({t, "_valid"}, 128'(va), 128'(eva));
    chk({t, "_done"},  128'(dn), 128'(edn));
    chk({t, "_busy"},  128'(bz), 128'(ebz));
  endtask

  logic [31:0] re, va, dn, bz;

  initial begin
    for (int i = 0; i < 16*DW; i++) begin
      rnd_x1[i] = 1'($urandom_range(0, 1));
      rnd_x2[i] = 1'($urandom_range(0, 1));
    end
    // Reset with random control and data inputs.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
      hold  = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    chk("rst_busy",  128'(busy), 128'(0));
    chk("rst_done",  128'(done), 128'(0));
    chk("rst_rd_en", 128'(rd_en), 128'(0));
    chk("rst_rd_addr", 128'(rd_addr), 128'(0));
    chk("rst_valid", 128'(valid), 128'(0));
    chk("rst_idx1",  128'(index_col_1), 128'(0));
    chk("rst_idx2",  128'(index_col_2), 128'(0));
    chk("rst_x1", 128'({x1_col1_r, x1_col1_i, x1_col2_r, x1_col2_i} != '0), 128'(0));
    chk("rst_x2", 128'({x2_col1_r, x2_col1_i, x2_col2_r, x2_col2_i} != '0), 128'(0));
    start = 1'b0; hold = 1'b0; rnd_mode = 1'b0; rst_n = 1'b1;
    repeat (2) @(negedge clk);

    push_frame(NB);
    run_seq(32'h1, 32'h0, 32'h0, 12, re, va, dn, bz);
    chk_seq("plain", re, va, dn, bz, 32'h1E, 32'hF0, 32'h100, 32'hFE);

    push_frame(NB);
    run_seq(32'h1, 32'h4, 32'h0, 13, re, va, dn, bz);
    chk_seq("hold", re, va, dn, bz, 32'h36, 32'h1B0, 32'h200, 32'h1FE);

    push_frame(NB);
    run_seq(32'h1, 32'h3, 32'h0, 13, re, va, dn, bz);
    chk_seq("start_hold", re, va, dn, bz, 32'h78, 32'h3C0, 32'h400, 32'h3FE);

    push_frame(NB); push_frame(NB);
    run_seq(32'h105, 32'h0, 32'h0, 20, re, va, dn, bz);
    chk_seq("restart", re, va, dn, bz, 32'h1E1E, 32'hF0F0, 32'h10100, 32'hFEFE);

    push_frame(2);
    run_seq(32'h1, 32'h0, 32'h60, 14, re, va, dn, bz);
    chk_seq("abort", re, va, dn, bz, 32'h1E, 32'h30, 32'h0, 32'h3E);

    push_frame(NB);
    run_seq(32'h1, 32'h0, 32'h0, 12, re, va, dn, bz);
    chk_seq("after_abort", re, va, dn, bz, 32'h1E, 32'hF0, 32'h100, 32'hFE);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
